// File: rtl/tpg_sink_checker.sv
// Traffic-generator sink: checks dest and per-source sequence order,
// keeps saturating counters and drives a programmable ready pattern.
module tpg_sink_checker #(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NODE         = 15,
    parameter int STALL_PERIOD = 0,
    parameter int SEQ_W        = WIDTH - 2*N_ADDR_WIDTH - 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [31:0]             rx_count,
    output logic [15:0]             seq_err_count,
    output logic [15:0]             dest_err_count,
    output logic [15:0]             proto_err_count,
    output logic                    error,
    output logic [N_ADDR_WIDTH-1:0] last_src,
    output logic [7:0]              last_id
);

    localparam int A  = N_ADDR_WIDTH;
    localparam int TN = 1 << A;
    localparam logic [A-1:0] NODE_A = A'(NODE);

    logic [A-1:0]     src;
    logic [A-1:0]     dest;
    logic [7:0]       id;
    logic [SEQ_W-1:0] seq;
    assign {src, dest, id, seq} = data_in;

    logic [SEQ_W-1:0] exp_tbl [TN];
    logic [SEQ_W-1:0] exp_seq;
    logic             ready_q;
    logic             rdy_nxt;
    logic             bad_seq;
    logic             bad_dest;
    logic             bad_proto;

    assign exp_seq   = exp_tbl[src];
    assign bad_seq   = (seq != exp_seq);
    assign bad_dest  = (dest != NODE_A);
    assign bad_proto = !ready_q;

    // Free-running stall counter; ready drops the cycle after the last count.
    if (STALL_PERIOD == 0) begin : g_nostall
        assign rdy_nxt = 1'b1;
    end else begin : g_stall
        localparam int CW = $clog2(STALL_PERIOD);
        localparam logic [CW-1:0] LAST = CW'(STALL_PERIOD - 1);
        logic [CW-1:0] cnt;
        always_ff @(posedge clk) begin
            if (rst)
                cnt <= '0;
            else if (cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
        assign rdy_nxt = (cnt != LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_out       <= 1'b0;
            ready_q         <= 1'b0;
            rx_count        <= '0;
            seq_err_count   <= '0;
            dest_err_count  <= '0;
            proto_err_count <= '0;
            error           <= 1'b0;
            last_src        <= '0;
            last_id         <= '0;
            for (int i = 0; i < TN; i++)
                exp_tbl[i] <= SEQ_W'(1);
        end else begin
            ready_out <= rdy_nxt;
            ready_q   <= ready_out;
            if (valid_in) begin
                last_src     <= src;
                last_id      <= id;
                exp_tbl[src] <= seq + 1'b1;
                if (rx_count != '1)
                    rx_count <= rx_count + 1'b1;
                if (bad_seq && seq_err_count != '1)
                    seq_err_count <= seq_err_count + 1'b1;
                if (bad_dest && dest_err_count != '1)
                    dest_err_count <= dest_err_count + 1'b1;
                if (bad_proto && proto_err_count != '1)
                    proto_err_count <= proto_err_count + 1'b1;
                if (bad_seq || bad_dest || bad_proto)
                    error <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && valid_in)
            $display("RECV t=%0t src=%0d dest=%0d id=%0d seq=%0d",
                     $time, src, dest, id, seq);
    end
`endif

endmodule

// File: doc/tpg_sink_checker.md
Name: tpg_sink_checker

Overview:
- Receiving end of the basic traffic generator's valid/ready link; attaches to the NoC output port of router NODE.
- Accepts flits formatted {src, dest, id, seq}, checks that each is addressed to this node, and checks per-source in-order delivery.
- Keeps saturating statistic/error counters and drives a programmable backpressure pattern on ready_out.
- Simulation-only: logs every received flit as a RECV line (time, src, dest, id, seq); this logging is excluded from synthesis.

Parameters:
- WIDTH, 32, flit data width.
- N, 16, number of NoC nodes.
- N_ADDR_WIDTH, $clog2(N), router address width.
- NODE, 15, router index this sink is attached to; expected dest field.
- STALL_PERIOD, 0, backpressure period in cycles. 0 = never stall. Values 1 and 2 are illegal.
- SEQ_W, WIDTH-2*N_ADDR_WIDTH-8, sequence field width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- data_in  in  WIDTH  flit: [W-1 -: A]=src, next A=dest, next 8=id, low SEQ_W=seq.
- valid_in  in  1  flit present this cycle.
- ready_out  out  1  permission for the sender to launch a flit on the next cycle.
- rx_count  out  32  flits accepted (saturating).
- seq_err_count  out  16  sequence mismatches (saturating).
- dest_err_count  out  16  flits whose dest != NODE (saturating).
- proto_err_count  out  16  flits arriving without prior permission (saturating).
- error  out  1  sticky; set on any error.
- last_src  out  N_ADDR_WIDTH  src field of the most recent flit.
- last_id  out  8  id field of the most recent flit.

Behaviour:
- Interface description: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - All outputs 0, including ready_out.
  - Stall counter 0.
  - All N expected-seq entries = 1, because a generator's first flit carries seq 1.
- Reset mid-operation: everything is reinitialised; a valid_in during the reset cycle is ignored.
- Acceptance:
  - Every cycle with valid_in=1 and rst=0 is a received flit. The sink never drops.
  - ready_out is advisory to the sender: it grants launch on the following cycle.
- ready_out (registered):
  - STALL_PERIOD=0: ready_out = 1 from the first cycle after reset deasserts.
  - Otherwise: a free-running counter counts 0..STALL_PERIOD-1 and wraps. ready_out is driven low for the one cycle following count == STALL_PERIOD-1, and is 1 otherwise.
- ready_q = ready_out delayed one cycle (reset 0). A flit with ready_q=0 increments proto_err_count; the flit is still checked and counted.
- Dest check: if dest != NODE, increment dest_err_count. The sequence check and table update still occur.
- Sequence check:
  - exp = table[src], read combinationally.
  - If seq == exp: no error.
  - Otherwise: increment seq_err_count.
  - In both cases table[src] <= seq+1 mod 2^SEQ_W. A mismatch therefore resynchronises, and wrap from all-ones to 0 is legal.
- Latency: all counters, error, last_src and last_id reflect a flit on the cycle after it is accepted (one-cycle latency).
- Simultaneous errors: a single flit may increment several error counters in the same cycle. Each counter increments by at most 1 per flit.
- Saturation: counters hold at their all-ones value; error stays 1 until reset.
- Back-to-back flits from the same src: the table write from cycle t must be visible to the read in cycle t+1 (no hazard).

Test Plan:
- Defaults; feed seq 1,2,3 from src 3, dest 15, id 7, one per cycle with STALL_PERIOD=0 -> rx_count=3, all error counts 0, last_src=3, last_id=7, error=0.
- Src 2 sends seq 1,2,4,5 -> seq_err_count=1 (at seq 4); seq 5 passes; rx_count=4.
- Flit with dest=9 and correct seq -> dest_err_count=1, seq_err_count=0, error=1 on the next cycle.
- STALL_PERIOD=4 -> ready_out pattern 1,1,1,0 repeating after reset. A valid_in asserted in the cycle after ready_out=0 -> proto_err_count=1 and rx_count still increments.
- Preload by sending src 5 seq 65535 then seq 0 -> no seq error (wrap). Then rst pulse, then seq 5 from src 5 -> seq_err_count=1 and rx_count=1 (reset cleared table and counters).
- Drive 65537 dest-error flits -> dest_err_count saturates at 65535 and holds.
